lcd_frame_feeder: RTL

//  Upstream feeder for the HD44780 LCD controller. Holds a 2-line text frame buffer that the rest of
//  the design writes by cell address. On request, sweeps the buffer into the controller as a command

---
 rtl/lcd_pkg.sv | 7 +
 rtl/lcd_refresh_timer.sv | 17 +
 rtl/lcd_frame_feeder.sv | 92 +++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: sweep states and HD44780 constants shared by the LCD feeder and controller.
package lcd_pkg;
   typedef enum logic [2:0] {IDLE, SET_L0, CHR_L0, SET_L1, CHR_L1} lcd_state_e;
   localparam logic [7:0] LCD_DDRAM_L0 = 8'h80;
   localparam logic [7:0] LCD_DDRAM_L1 = 8'hC0;
   localparam logic [7:0] ASCII_SPACE  = 8'h20;
endpackage

// File: rtl/lcd_refresh_timer.sv
// lcd_refresh_timer: free-running period counter; tick_o is high for one cycle every PERIOD cycles.
module lcd_refresh_timer #(
   parameter int PERIOD = 5_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);
   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick_o = cnt_q == CW'(PERIOD - 1);
   always_comb cnt_d = tick_o ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/lcd_frame_feeder.sv
// lcd_frame_feeder: 2-line frame buffer swept into the HD44780 controller over valid/ready.
// Define LCD_AUTO_REFRESH_EN to add a periodic sweep request from lcd_refresh_timer.
module lcd_frame_feeder
   import lcd_pkg::*;
#(
   parameter int LINE_LEN   = 16,
   parameter int CLK_HZ     = 50_000_000,
   parameter int REFRESH_MS = 100,
   localparam int AW = $clog2(2 * LINE_LEN),
   localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_char_i,
   input  logic          refresh_i,
   output logic          busy_o,
   output logic          cmd_valid_o,
   output logic          cmd_rs_o,
   output logic [7:0]    cmd_data_o,
   input  logic          cmd_ready_i
);
   localparam int PERIOD = CLK_HZ / 1000 * REFRESH_MS;
   localparam logic [AW:0] NCELL = (AW + 1)'(2 * LINE_LEN);
   lcd_state_e    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic          pend_q, pend_d, rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    cells_q [2*LINE_LEN];
   logic          tick, req, busy, xfer, last;
   logic [AW-1:0] rd_idx;
`ifdef LCD_AUTO_REFRESH_EN
   lcd_refresh_timer #(.PERIOD(PERIOD)) u_timer (.clk_i(clk_i), .rst_i(rst_i), .tick_o(tick));
`else
   logic unused_period;
   assign unused_period = ^PERIOD;
   assign tick = 1'b0;
`endif
   assign req         = refresh_i | tick;
   assign busy        = state_q != IDLE;
   assign xfer        = busy && cmd_ready_i;
   assign last        = col_q == CW'(LINE_LEN - 1);
   assign rd_idx      = AW'(col_q) + AW'(1) + ((state_q == CHR_L1) ? AW'(LINE_LEN) : AW'(0));
   assign busy_o      = busy;
   assign cmd_valid_o = busy;
   assign cmd_rs_o    = rs_q;
   assign cmd_data_o  = data_q;
   // The next byte is loaded on the transfer edge, so cells read here are pre-write values.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      pend_d  = pend_q | (req && busy);
      rs_d    = rs_q;
      data_d  = data_q;
      case (state_q)
         IDLE:   if (req) {state_d, rs_d, data_d} = {SET_L0, 1'b0, LCD_DDRAM_L0};
         SET_L0: if (xfer) {state_d, rs_d, data_d} = {CHR_L0, 1'b1, cells_q[0]};
         SET_L1: if (xfer) {state_d, rs_d, data_d} = {CHR_L1, 1'b1, cells_q[LINE_LEN]};
         CHR_L0, CHR_L1: begin
            if (xfer && !last) begin
               col_d  = col_q + 1'b1;
               data_d = cells_q[rd_idx];
            end else if (xfer) begin
               col_d = '0;
               rs_d  = 1'b0;
               if (state_q == CHR_L0) {state_d, data_d} = {SET_L1, LCD_DDRAM_L1};
               else if (pend_d)       {state_d, data_d, pend_d} = {SET_L0, LCD_DDRAM_L0, 1'b0};
               else                   {state_d, data_d} = {IDLE, 8'h00};
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         col_q   <= '0;
         pend_q  <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         for (int i = 0; i < 2 * LINE_LEN; i++) cells_q[i] <= ASCII_SPACE;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         pend_q  <= pend_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         if (wr_en_i && ({1'b0, wr_addr_i} < NCELL)) cells_q[wr_addr_i] <= wr_char_i;
      end
   end
endmodule
